// File: rtl/uart_pkg.sv
// Shared UART types and sizing helpers.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_IDLE
  } uart_rx_state_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous single-bit input.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic r_meta;
  logic r_q;

  // NOTE: sequential state uses non-blocking assignments so both flops sample
  // the pre-edge values and the chain really is two stages deep.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_meta <= RST_VAL;
      r_q    <= RST_VAL;
    end else begin
      r_meta <= d_i;
      r_q    <= r_meta;
    end
  end

  assign q_o = r_q;

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: majority-voted sampling, optional parity,
// one or two stop bits, glitch-rejected start, parity/frame/break flags.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] rx_dout_o,
  output logic                 rx_done_tick_o,
  output logic                 rx_active_o,
  output logic                 parity_err_o,
  output logic                 frame_err_o,
  output logic                 break_o
);

  localparam int TCK_W = cnt_w(CLKS_PER_BIT);
  localparam int BIT_W = cnt_w(DATA_BITS + 1);
  localparam int MID   = CLKS_PER_BIT / 2;

  localparam logic [TCK_W-1:0] TCK_S0   = TCK_W'(MID - 1);
  localparam logic [TCK_W-1:0] TCK_S1   = TCK_W'(MID);
  localparam logic [TCK_W-1:0] TCK_DEC  = TCK_W'(MID + 1);
  localparam logic [TCK_W-1:0] TCK_LAST = TCK_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic             ODD_BIT  = (PARITY_ODD != 0);

  uart_rx_state_e       r_state, w_state_next;
  logic                 w_rxs;
  logic [TCK_W-1:0]     r_tck;
  logic [BIT_W-1:0]     r_bit_cnt;
  logic                 r_stop_idx;
  logic                 r_s0, r_s1;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_err_pend, r_frm_err_pend;
  logic [DATA_BITS-1:0] r_dout;
  logic                 r_done, r_active, r_par_err, r_frm_err, r_break;
  logic                 w_dec, w_end, w_vote, w_last_stop, w_commit, w_frm_err_final;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (rx_i),
    .q_o   (w_rxs)
  );

  assign w_dec           = (r_tck == TCK_DEC);
  assign w_end           = (r_tck == TCK_LAST);
  assign w_vote          = (r_s0 & r_s1) | (r_s0 & w_rxs) | (r_s1 & w_rxs);
  assign w_last_stop     = (STOP_BITS == 1) || r_stop_idx;
  assign w_commit        = (r_state == S_STOP) && w_dec && w_last_stop;
  assign w_frm_err_final = r_frm_err_pend | ~w_vote;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // NOTE: the default assignment up front keeps this block purely
  // combinational; a path that left w_state_next unassigned would infer a latch.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:      if (!w_rxs) w_state_next = S_START;
      S_START: begin
        if (w_dec && w_vote) w_state_next = S_IDLE;
        else if (w_end)      w_state_next = S_DATA;
      end
      S_DATA:      if (w_end && r_bit_cnt == BIT_LAST)
                     w_state_next = (PARITY_EN != 0) ? S_PARITY : S_STOP;
      S_PARITY:    if (w_end) w_state_next = S_STOP;
      S_STOP:      if (w_dec && w_last_stop)
                     w_state_next = w_vote ? S_IDLE : S_WAIT_IDLE;
      S_WAIT_IDLE: if (w_rxs) w_state_next = S_IDLE;
      default:     w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_tck          <= '0;
      r_bit_cnt      <= '0;
      r_stop_idx     <= 1'b0;
      r_s0           <= 1'b1;
      r_s1           <= 1'b1;
      r_shift        <= '0;
      r_par_err_pend <= 1'b0;
      r_frm_err_pend <= 1'b0;
      r_dout         <= '0;
      r_done         <= 1'b0;
      r_active       <= 1'b0;
      r_par_err      <= 1'b0;
      r_frm_err      <= 1'b0;
      r_break        <= 1'b0;
    end else begin
      r_done   <= 1'b0;
      r_active <= (w_state_next == S_START) || (w_state_next == S_DATA) ||
                  (w_state_next == S_PARITY) || (w_state_next == S_STOP);

      // Bit timing restarts on every state change and every bit boundary.
      if (w_state_next != r_state || w_end ||
          r_state == S_IDLE || r_state == S_WAIT_IDLE)
        r_tck <= '0;
      else
        r_tck <= r_tck + TCK_W'(1);

      if (r_tck == TCK_S0) r_s0 <= w_rxs;
      if (r_tck == TCK_S1) r_s1 <= w_rxs;

      case (r_state)
        S_IDLE: begin
          r_bit_cnt      <= '0;
          r_stop_idx     <= 1'b0;
          r_par_err_pend <= 1'b0;
          r_frm_err_pend <= 1'b0;
        end
        S_DATA: begin
          if (w_dec) r_shift   <= {w_vote, r_shift[DATA_BITS-1:1]};
          if (w_end) r_bit_cnt <= r_bit_cnt + BIT_W'(1);
        end
        S_PARITY: begin
          if (w_dec) r_par_err_pend <= ((^r_shift) ^ w_vote) != ODD_BIT;
        end
        S_STOP: begin
          if (w_dec && !w_vote) r_frm_err_pend <= 1'b1;
          if (w_end)            r_stop_idx     <= 1'b1;
          if (w_commit) begin
            r_dout    <= r_shift;
            r_par_err <= r_par_err_pend;
            r_frm_err <= w_frm_err_final;
            r_break   <= w_frm_err_final && (r_shift == '0);
            r_done    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rx_dout_o      = r_dout;
  assign rx_done_tick_o = r_done;
  assign rx_active_o    = r_active;
  assign parity_err_o   = r_par_err;
  assign frame_err_o    = r_frm_err;
  assign break_o        = r_break;

endmodule

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

Parametrised UART receiver, successor to the fixed 8N1 receiver. Adds configurable data width, optional even/odd parity, one or two stop bits, a 2-flop input synchroniser, 3-sample majority voting, start-bit glitch rejection, and parity/framing/break error reporting. It sits between the serial pin and the byte-level consumer; each received frame produces a single-cycle done tick.

## Interface
- CLKS_PER_BIT, 10: clock cycles per bit; legal values ≥ 4
- DATA_BITS, 8: data bits per frame, 5..9
- PARITY_EN, 0: 1 = parity bit present after the data bits
- PARITY_ODD, 0: 1 = odd parity, 0 = even (ignored when PARITY_EN = 0)
- STOP_BITS, 1: number of stop bits, 1 or 2
- clk_i  in  1  single clock
- rst_i  in  1  asynchronous, active-high reset
- rx_i  in  1  serial line; asynchronous; idles high
- rx_dout_o  out  DATA_BITS  last received word, LSB first on the wire
- rx_done_tick_o  out  1  one-cycle pulse when a frame completes
- rx_active_o  out  1  high while a frame is being received
- parity_err_o  out  1  parity mismatch on the last frame
- frame_err_o  out  1  a stop bit was sampled 0 on the last frame
- break_o  out  1  last frame was all-zero data with stop = 0

## Operation
- rx_i passes through a 2-flop synchroniser (reset value 1); the FSM sees only rxs.
- Bit counter tck runs 0..CLKS_PER_BIT-1. MID = CLKS_PER_BIT/2 (integer division). The bit value is the majority of rxs sampled at tck = MID-1, MID, and MID+1. The decision is made at tck = MID+1.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
- IDLE: when rxs = 0, go to START with tck = 0.
- START: at the decision point, a majority of 1 is a glitch → return to IDLE with no tick and no flags changed. A majority of 0 continues; at tck = CLKS_PER_BIT-1 go to DATA.
- DATA: shift the voted bits in LSB first. After DATA_BITS bits, go to PARITY if PARITY_EN, otherwise to STOP.
- PARITY: parity error if XOR(data, parity bit) ≠ PARITY_ODD.
- STOP: vote each stop bit. Any stop bit that votes 0 is a frame error. At the decision point of the last stop bit:
  - update rx_dout_o and all error flags;
  - pulse rx_done_tick_o on the next cycle;
  - go to IDLE if that stop bit voted 1, otherwise to WAIT_IDLE.
- The receiver does not wait for the end of the stop bit, so back-to-back frames are captured.
- WAIT_IDLE: stay until rxs = 1, then go to IDLE. This prevents a held-low line from re-triggering.
- break_o = frame error AND data = 0.
- rx_dout_o and all flags hold their values until the next completed frame; a glitch-rejected start does not change them.

## Timing
- Reset values: rx_dout_o = 0, all flags = 0, rx_done_tick_o = 0, rx_active_o = 0, FSM = IDLE, counters = 0.
- rx_active_o is high in START, DATA, PARITY and STOP; low in IDLE and WAIT_IDLE. It is registered and rises 1 cycle after IDLE sees rxs = 0.
- Latency from the rx_i falling edge to entering START: 3 cycles (2 synchroniser cycles + 1 FSM cycle).
- rx_done_tick_o rises 1 cycle after the last stop-bit decision. It is exactly 1 cycle wide and coincides with the rx_dout_o and flag update.
- Asserting rst_i mid-frame clears everything immediately. No partial word is output and no tick is generated.
- A falling edge arriving during STOP after the decision point is seen in IDLE on the next cycle; no frame is lost.

## Structure
- Package uart_pkg holds:
  - state enum uart_rx_state_e;
  - a localparam function computing the counter widths, clog2(CLKS_PER_BIT) and clog2(DATA_BITS+1).
- Sub-module sync_2ff: a parametrised-reset-value 2-flop synchroniser, reusable by the transmitter and other blocks.
- The voting, counters and FSM stay in uart_rx_cfg.

## Test plan
- Defaults, 10 ns clock, 100 ns bits. Send 0x00, 0xAB, 0xFD, each followed by 400 ns idle → three ticks; dout = 0x00, 0xAB, 0xFD; all flags 0.
- PARITY_EN=1, PARITY_ODD=0. Send 0xAB with correct parity bit 1 → parity_err 0. Resend with parity bit 0 → tick, dout = 0xAB, parity_err = 1.
- 30 ns low pulse on an idle line → no tick, rx_active pulses then returns to 0, dout unchanged. A single-cycle 1 glitch inside a 0 data bit is voted out → correct byte.
- Frame 0x55 with stop bit 0, line then held low 2000 ns → tick, frame_err = 1, break_o = 0. The FSM stays in WAIT_IDLE with no further ticks until rx_i returns high. An all-zero frame with stop 0 → break_o = 1.
- DATA_BITS=7, STOP_BITS=2. Send 0x3C, 0x41 back-to-back with no idle gap → two ticks with the correct values. A second stop bit of 0 → frame_err = 1.
- Assert rst_i for one cycle during bit 4 of a frame → outputs go to their reset values, no tick. The following frame 0x9E is received correctly.
